// File: rtl/memory_control_n.sv
// memory_control_n: shared-RAM arbiter and snooping coherence controller
// for CPUS instruction/data cache pairs.
module memory_control_n #(
    parameter int CPUS        = 2,
    parameter int WORD_W      = 32,
    parameter int BLOCK_WORDS = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [CPUS-1:0]          iREN,
    input  logic [CPUS-1:0]          dREN,
    input  logic [CPUS-1:0]          dWEN,
    input  logic [CPUS-1:0]          cctrans,
    input  logic [CPUS-1:0]          ccwrite,
    input  logic [CPUS*WORD_W-1:0]   iaddr,
    input  logic [CPUS*WORD_W-1:0]   daddr,
    input  logic [CPUS*WORD_W-1:0]   dstore,
    output logic [CPUS-1:0]          iwait,
    output logic [CPUS-1:0]          dwait,
    output logic [CPUS-1:0]          ccwait,
    output logic [CPUS-1:0]          ccinv,
    output logic [CPUS*WORD_W-1:0]   iload,
    output logic [CPUS*WORD_W-1:0]   dload,
    output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
    output logic                     ramREN,
    output logic                     ramWEN,
    output logic [WORD_W-1:0]        ramaddr,
    output logic [WORD_W-1:0]        ramstore,
    input  logic [WORD_W-1:0]        ramload,
    input  logic [1:0]               ramstate
);

    localparam int         IW        = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam logic [1:0] RS_ACCESS = 2'b10;
    localparam logic [2:0] LAST_WORD = 3'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        XFER,
        MEMRD,
        INV
    } state_t;

    state_t            r_state;
    logic [IW-1:0]     r_req;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_rr;
    logic [IW-1:0]     r_irr;
    logic [WORD_W-1:0] r_addr;
    logic              r_wr;
    logic [2:0]        r_cnt;

    logic              w_access;
    logic              w_any_cc;
    logic              w_any_dw;
    logic              w_any_ir;
    logic              w_acks;
    logic              w_dirty;
    logic              w_last;
    logic [IW-1:0]     w_cgnt;
    logic [IW-1:0]     w_dgnt;
    logic [IW-1:0]     w_ignt;
    logic [IW-1:0]     w_own;

    // First requester at or after ptr, wrapping around.
    function automatic logic [IW-1:0] rr_pick(
        input logic [CPUS-1:0] req,
        input logic [IW-1:0]   ptr
    );
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        pick = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            idx = IW'((int'(ptr) + k) % CPUS);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] p);
        return (int'(p) == CPUS - 1) ? '0 : IW'(int'(p) + 1);
    endfunction

    function automatic logic [WORD_W-1:0] word(
        input logic [CPUS*WORD_W-1:0] v,
        input logic [IW-1:0]          i
    );
        logic [WORD_W-1:0] w;
        w = '0;
        for (int j = 0; j < CPUS; j++) begin
            if (IW'(j) == i) w = v[j*WORD_W +: WORD_W];
        end
        return w;
    endfunction

    assign w_access = (ramstate == RS_ACCESS);
    assign w_any_cc = |cctrans;
    assign w_any_dw = |dWEN;
    assign w_any_ir = |iREN;
    assign w_last   = (r_cnt == LAST_WORD);
    assign w_cgnt   = rr_pick(cctrans, r_rr);
    assign w_dgnt   = rr_pick(dWEN, r_rr);
    assign w_ignt   = rr_pick(iREN, r_irr);

    // Snoop acks from everyone but the requester; lowest dirty hit owns.
    always_comb begin
        w_acks  = 1'b1;
        w_dirty = 1'b0;
        w_own   = '0;
        for (int j = CPUS - 1; j >= 0; j--) begin
            if (IW'(j) != r_req) begin
                if (!cctrans[j]) w_acks = 1'b0;
                if (cctrans[j] && ccwrite[j]) begin
                    w_dirty = 1'b1;
                    w_own   = IW'(j);
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_owner <= '0;
            r_rr    <= '0;
            r_irr   <= '0;
            r_addr  <= '0;
            r_wr    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_any_cc) begin
                        r_req   <= w_cgnt;
                        r_addr  <= word(daddr, w_cgnt);
                        r_wr    <= ccwrite[w_cgnt];
                        r_state <= SNOOP;
                    end else if (w_any_dw) begin
                        if (w_access) r_rr <= next_ptr(w_dgnt);
                    end else if (w_any_ir) begin
                        if (w_access) r_irr <= next_ptr(w_ignt);
                    end
                end
                SNOOP: begin
                    if (w_acks) begin
                        if (w_dirty) begin
                            r_owner <= w_own;
                            r_state <= XFER;
                        end else if (dREN[r_req]) begin
                            r_state <= MEMRD;
                        end else begin
                            r_state <= INV;
                        end
                    end
                end
                XFER, MEMRD: begin
                    if (w_access) begin
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_rr    <= next_ptr(r_req);
                            r_state <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 3'd1;
                        end
                    end
                end
                INV: begin
                    r_cnt   <= '0;
                    r_rr    <= next_ptr(r_req);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        iload       = {CPUS{ramload}};
        dload       = {CPUS{ramload}};
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (!RST) begin
            unique case (r_state)
                IDLE: begin
                    if (!w_any_cc && w_any_dw) begin
                        ramWEN   = 1'b1;
                        ramaddr  = word(daddr, w_dgnt);
                        ramstore = word(dstore, w_dgnt);
                        if (w_access) dwait[w_dgnt] = 1'b0;
                    end else if (!w_any_cc && w_any_ir) begin
                        ramREN  = 1'b1;
                        ramaddr = word(iaddr, w_ignt);
                        if (w_access) iwait[w_ignt] = 1'b0;
                    end
                end
                SNOOP: begin
                    for (int j = 0; j < CPUS; j++) begin
                        if (IW'(j) != r_req) begin
                            ccsnoopaddr[j*WORD_W +: WORD_W] = r_addr;
                            ccinv[j] = r_wr;
                        end
                    end
                end
                XFER: begin
                    ramWEN   = 1'b1;
                    ramaddr  = word(daddr, r_owner);
                    ramstore = word(dstore, r_owner);
                    for (int j = 0; j < CPUS; j++) begin
                        if (IW'(j) == r_req)
                            dload[j*WORD_W +: WORD_W] = word(dstore, r_owner);
                    end
                    if (w_access) begin
                        dwait[r_req]   = 1'b0;
                        dwait[r_owner] = 1'b0;
                    end
                end
                MEMRD: begin
                    ramREN  = 1'b1;
                    ramaddr = word(daddr, r_req);
                    if (w_access) dwait[r_req] = 1'b0;
                end
                INV: ;
                default: ;
            endcase
            if (r_state != IDLE) begin
                for (int j = 0; j < CPUS; j++) begin
                    if (IW'(j) != r_req) ccwait[j] = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_memory_control_n.sv
// Directed bench for memory_control_n: a 2-CPU and a 4-CPU instance
// share clock, reset and the RAM response signals.
module tb_memory_control_n;

    localparam int W = 32;
    localparam logic [1:0] FR = 2'd0, BU = 2'd1, AC = 2'd2, ER = 2'd3;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic [1:0]   ramstate;
    logic [W-1:0] ramload;

    logic [3:0]     iREN, dREN, dWEN, cctrans, ccwrite;
    logic [4*W-1:0] iaddr, daddr, dstore;
    logic [3:0]     iwait, dwait, ccwait, ccinv;
    logic [4*W-1:0] iload, dload, snp;
    logic           ramREN, ramWEN;
    logic [W-1:0]   ramaddr, ramstore;

    logic [1:0]     iREN2, dREN2, dWEN2, cct2, ccw2;
    logic [2*W-1:0] iaddr2, daddr2, dstore2;
    logic [1:0]     iwait2, dwait2, ccwait2, ccinv2;
    logic [2*W-1:0] iload2, dload2, snp2;
    logic           ren2, wen2;
    logic [W-1:0]   raddr2, rstore2;

    memory_control_n #(.CPUS(4), .WORD_W(W), .BLOCK_WORDS(2)) u4 (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore),
        .iwait(iwait), .dwait(dwait), .ccwait(ccwait), .ccinv(ccinv),
        .iload(iload), .dload(dload), .ccsnoopaddr(snp),
        .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    memory_control_n #(.CPUS(2), .WORD_W(W), .BLOCK_WORDS(2)) u2 (
        .CLK(CLK), .RST(RST),
        .iREN(iREN2), .dREN(dREN2), .dWEN(dWEN2),
        .cctrans(cct2), .ccwrite(ccw2),
        .iaddr(iaddr2), .daddr(daddr2), .dstore(dstore2),
        .iwait(iwait2), .dwait(dwait2), .ccwait(ccwait2), .ccinv(ccinv2),
        .iload(iload2), .dload(dload2), .ccsnoopaddr(snp2),
        .ramREN(ren2), .ramWEN(wen2),
        .ramaddr(raddr2), .ramstore(rstore2),
        .ramload(ramload), .ramstate(ramstate)
    );

    typedef struct {
        logic [3:0]  dwen;
        logic [3:0]  iren;
        logic [1:0]  rs;
        logic [3:0]  dwait;
        logic [3:0]  iwait;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] store;
    } vec_t;

    vec_t tbl[10];
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(negedge CLK);
    endtask

    initial begin
        tbl[0] = '{4'h0, 4'h0, FR, 4'hF, 4'hF, 1'b0, 1'b0, 32'h0,    32'h0};
        tbl[1] = '{4'h6, 4'h1, BU, 4'hF, 4'hF, 1'b0, 1'b1, 32'h2001, 32'hA001};
        tbl[2] = '{4'h6, 4'h1, ER, 4'hF, 4'hF, 1'b0, 1'b1, 32'h2001, 32'hA001};
        tbl[3] = '{4'h6, 4'h1, AC, 4'hD, 4'hF, 1'b0, 1'b1, 32'h2001, 32'hA001};
        tbl[4] = '{4'h6, 4'h1, AC, 4'hB, 4'hF, 1'b0, 1'b1, 32'h2002, 32'hA002};
        tbl[5] = '{4'h3, 4'h0, AC, 4'hE, 4'hF, 1'b0, 1'b1, 32'h2000, 32'hA000};
        tbl[6] = '{4'h0, 4'h9, AC, 4'hF, 4'hE, 1'b1, 1'b0, 32'h1000, 32'h0};
        tbl[7] = '{4'h0, 4'h9, AC, 4'hF, 4'h7, 1'b1, 1'b0, 32'h1003, 32'h0};
        tbl[8] = '{4'h0, 4'h9, BU, 4'hF, 4'hF, 1'b1, 1'b0, 32'h1000, 32'h0};
        tbl[9] = '{4'h0, 4'h4, AC, 4'hF, 4'hB, 1'b1, 1'b0, 32'h1002, 32'h0};

        RST = 1'b1;
        ramstate = FR; ramload = '0;
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        for (int j = 0; j < 4; j++) begin
            iaddr[j*W +: W]  = 32'h1000 + j;
            daddr[j*W +: W]  = 32'h2000 + j;
            dstore[j*W +: W] = 32'hA000 + j;
        end
        iREN2 = '0; dREN2 = '0; dWEN2 = '0; cct2 = '0; ccw2 = '0;
        iaddr2 = '0; daddr2 = '0; dstore2 = '0;

        // reset holds waits high even with a write ready to complete
        nxt;
        dWEN = 4'hF; dWEN2 = 2'b11; ramstate = AC;
        #1;
        chk("rst_dwait", 64'(dwait), 64'(4'hF));
        chk("rst_iwait", 64'(iwait), 64'(4'hF));
        chk("rst_ccwait", 64'(ccwait), 64'(4'h0));
        chk("rst_ramwen", 64'(ramWEN), 64'(1'b0));
        chk("rst_ramren", 64'(ramREN), 64'(1'b0));
        chk("rst_dwait2", 64'(dwait2), 64'(2'b11));
        chk("rst_wen2", 64'(wen2), 64'(1'b0));
        dWEN = '0; dWEN2 = '0; ramstate = FR;
        nxt;
        RST = 1'b0;

        // 2-CPU clean read miss through MEMRD
        cct2 = 2'b01; dREN2 = 2'b01; daddr2[W-1:0] = 32'h100;
        #1;
        chk("c2_idle_dwait", 64'(dwait2), 64'(2'b11));
        nxt;
        cct2 = 2'b11; ccw2 = 2'b00;
        #1;
        chk("c2_snoop_ccwait", 64'(ccwait2), 64'(2'b10));
        chk("c2_snoop_addr", 64'(snp2[2*W-1:W]), 64'(32'h100));
        chk("c2_snoop_inv", 64'(ccinv2), 64'(2'b00));
        nxt;
        cct2 = 2'b00; ramstate = AC; ramload = 32'h1111_1111;
        #1;
        chk("c2_rd_ren", 64'(ren2), 64'(1'b1));
        chk("c2_rd_addr", 64'(raddr2), 64'(32'h100));
        chk("c2_rd_dwait0", 64'(dwait2), 64'(2'b10));
        chk("c2_rd_dload0", 64'(dload2[W-1:0]), 64'(32'h1111_1111));
        nxt;
        ramload = 32'h2222_2222;
        #1;
        chk("c2_rd_dwait1", 64'(dwait2), 64'(2'b10));
        chk("c2_rd_dload1", 64'(dload2[W-1:0]), 64'(32'h2222_2222));
        nxt;
        dREN2 = '0;
        #1;
        chk("c2_back_ren", 64'(ren2), 64'(1'b0));
        chk("c2_back_dwait", 64'(dwait2), 64'(2'b11));
        chk("c2_back_ccwait", 64'(ccwait2), 64'(2'b00));

        // 4-CPU IDLE arbitration table
        for (int i = 0; i < 10; i++) begin
            dWEN = tbl[i].dwen; iREN = tbl[i].iren; ramstate = tbl[i].rs;
            #1;
            chk($sformatf("t%0d_dwait", i), 64'(dwait), 64'(tbl[i].dwait));
            chk($sformatf("t%0d_iwait", i), 64'(iwait), 64'(tbl[i].iwait));
            chk($sformatf("t%0d_ren", i), 64'(ramREN), 64'(tbl[i].ren));
            chk($sformatf("t%0d_wen", i), 64'(ramWEN), 64'(tbl[i].wen));
            chk($sformatf("t%0d_addr", i), 64'(ramaddr), 64'(tbl[i].addr));
            chk($sformatf("t%0d_store", i), 64'(ramstore), 64'(tbl[i].store));
            nxt;
        end

        // writeback beats fetch; fetch waits until writeback completes
        dWEN = 4'b0010; iREN = 4'b0001; ramstate = BU;
        #1;
        chk("wb_busy_iwait", 64'(iwait), 64'(4'hF));
        chk("wb_busy_wen", 64'(ramWEN), 64'(1'b1));
        chk("wb_busy_addr", 64'(ramaddr), 64'(32'h2001));
        nxt;
        ramstate = AC;
        #1;
        chk("wb_acc_dwait", 64'(dwait), 64'(4'hD));
        chk("wb_acc_iwait", 64'(iwait), 64'(4'hF));
        nxt;
        dWEN = '0;
        #1;
        chk("if_acc_iwait", 64'(iwait), 64'(4'hE));
        chk("if_acc_ren", 64'(ramREN), 64'(1'b1));
        chk("if_acc_addr", 64'(ramaddr), 64'(32'h1000));
        nxt;

        // two requesters with rr_ptr=2: CPU3 first
        iREN = '0; dWEN = 4'b0010; cctrans = 4'b1010; dREN = 4'b1010;
        #1;
        chk("cc_idle_wen", 64'(ramWEN), 64'(1'b0));
        chk("cc_idle_dwait", 64'(dwait), 64'(4'hF));
        nxt;
        dWEN = '0; cctrans = 4'b1111; ramstate = FR;
        #1;
        chk("cc3_ccwait", 64'(ccwait), 64'(4'b0111));
        chk("cc3_snp0", 64'(snp[W-1:0]), 64'(32'h2003));
        chk("cc3_snp3", 64'(snp[4*W-1:3*W]), 64'(32'h0));
        chk("cc3_inv", 64'(ccinv), 64'(4'h0));
        chk("cc3_ren", 64'(ramREN), 64'(1'b0));
        nxt;
        cctrans = 4'b0010; ramstate = BU; ramload = 32'h5555_0001;
        #1;
        chk("cc3_rd_ren", 64'(ramREN), 64'(1'b1));
        chk("cc3_rd_addr", 64'(ramaddr), 64'(32'h2003));
        chk("cc3_rd_busy", 64'(dwait), 64'(4'hF));
        chk("cc3_rd_dload", 64'(dload[4*W-1:3*W]), 64'(32'h5555_0001));
        nxt;
        ramstate = AC;
        #1;
        chk("cc3_rd_w0", 64'(dwait), 64'(4'h7));
        nxt;
        #1;
        chk("cc3_rd_w1", 64'(dwait), 64'(4'h7));
        chk("cc3_rd_ccwait", 64'(ccwait), 64'(4'b0111));
        nxt;

        // CPU1 next (rr wrapped to 0), write-intent upgrade -> INV
        cctrans = 4'b1010; ccwrite = 4'b0010; dREN = '0; ramstate = FR;
        #1;
        chk("cc1_idle_ccwait", 64'(ccwait), 64'(4'h0));
        nxt;
        cctrans = 4'b0001;
        #1;
        chk("cc1_ccwait", 64'(ccwait), 64'(4'b1101));
        chk("cc1_inv", 64'(ccinv), 64'(4'b1101));
        chk("cc1_snp0", 64'(snp[W-1:0]), 64'(32'h2001));
        nxt;
        cctrans = 4'b1101;
        #1;
        chk("cc1_wait_ack", 64'(ccinv), 64'(4'b1101));
        nxt;
        cctrans = '0; ccwrite = '0; ramstate = AC;
        #1;
        chk("inv_ccwait", 64'(ccwait), 64'(4'b1101));
        chk("inv_ccinv", 64'(ccinv), 64'(4'h0));
        chk("inv_ren", 64'(ramREN), 64'(1'b0));
        chk("inv_wen", 64'(ramWEN), 64'(1'b0));
        nxt;
        #1;
        chk("inv_back_ccwait", 64'(ccwait), 64'(4'h0));
        chk("inv_back_dwait", 64'(dwait), 64'(4'hF));
        nxt;

        // CPU0 reads, CPU2 supplies dirty 0x200; reset on second word
        daddr[W-1:0] = 32'h200; daddr[3*W-1:2*W] = 32'h200;
        dstore[3*W-1:2*W] = 32'hCAFE_0002;
        cctrans = 4'b0001; dREN = 4'b0001; ramstate = FR;
        nxt;
        cctrans = 4'b1111; ccwrite = 4'b0100;
        #1;
        chk("x_ccwait", 64'(ccwait), 64'(4'b1110));
        chk("x_inv", 64'(ccinv), 64'(4'h0));
        nxt;
        cctrans = '0; ccwrite = '0; ramstate = BU;
        #1;
        chk("x_wen", 64'(ramWEN), 64'(1'b1));
        chk("x_ren", 64'(ramREN), 64'(1'b0));
        chk("x_addr", 64'(ramaddr), 64'(32'h200));
        chk("x_store", 64'(ramstore), 64'(32'hCAFE_0002));
        chk("x_dload0", 64'(dload[W-1:0]), 64'(32'hCAFE_0002));
        chk("x_busy_dwait", 64'(dwait), 64'(4'hF));
        chk("x_busy_ccwait", 64'(ccwait), 64'(4'b1110));
        nxt;
        ramstate = AC;
        #1;
        chk("x_acc_dwait", 64'(dwait), 64'(4'b1010));
        nxt;
        ramstate = BU;
        #1;
        chk("x_w1_wen", 64'(ramWEN), 64'(1'b1));
        chk("x_w1_dwait", 64'(dwait), 64'(4'hF));
        RST = 1'b1;
        #1;
        chk("x_rst_dwait", 64'(dwait), 64'(4'hF));
        chk("x_rst_iwait", 64'(iwait), 64'(4'hF));
        chk("x_rst_wen", 64'(ramWEN), 64'(1'b0));
        chk("x_rst_ccwait", 64'(ccwait), 64'(4'h0));
        nxt;
        RST = 1'b0; ramstate = AC;
        #1;
        chk("x_post_wen", 64'(ramWEN), 64'(1'b0));
        chk("x_post_ren", 64'(ramREN), 64'(1'b0));
        chk("x_post_dwait", 64'(dwait), 64'(4'hF));
        chk("x_post_ccwait", 64'(ccwait), 64'(4'h0));
        nxt;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_control_n.md
MEMORY_CONTROL_N -- requirements
Module: memory_control_n

Interface
REQ-001 Parameter CPUS, default 2, number of cache pairs (2..8).
REQ-002 Parameter WORD_W, default 32, data/address width.
REQ-003 Parameter BLOCK_WORDS, default 2, words per coherence transfer (1..4).
REQ-004 CLK  in  1  single clock; all state on rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 iREN, dREN, dWEN, cctrans, ccwrite  in  CPUS each  per-CPU cache requests; cctrans=coherence request or snoop ack, ccwrite=write intent (requester) or dirty hit (snooper).
REQ-007 iaddr, daddr, dstore  in  CPUS x WORD_W  per-CPU addresses and store data.
REQ-008 iwait, dwait, ccwait, ccinv  out  CPUS each  per-CPU stall, snoop-request and invalidate strobes.
REQ-009 iload, dload, ccsnoopaddr  out  CPUS x WORD_W  per-CPU load data and snoop address.
REQ-010 ramREN, ramWEN  out  1; ramaddr, ramstore  out  WORD_W; ramload  in  WORD_W; ramstate  in  2 (FREE, BUSY, ACCESS, ERROR).

Function
REQ-011 FSM states: IDLE, SNOOP, XFER, MEMRD, INV; reset state IDLE.
REQ-012 IDLE: if any cctrans asserted, grant requester R by round-robin starting at rr_ptr, latch R and its daddr and ccwrite, go SNOOP next cycle.
REQ-013 SNOOP: ccwait[j]=1 and ccsnoopaddr[j]=latched address for every j!=R; ccinv[j]=latched ccwrite.
REQ-014 SNOOP exits only when cctrans[j]=1 for all j!=R; if any such j has ccwrite[j]=1, owner O = lowest such j, go XFER; else go MEMRD if dREN[R], else INV.
REQ-015 XFER: dload[R]=dstore[O]; ramWEN=1, ramaddr=daddr[O], ramstore=dstore[O]; on ramstate==ACCESS, dwait[R]=0 and dwait[O]=0 same cycle, word counter increments.
REQ-016 MEMRD: ramREN=1, ramaddr=daddr[R], dload[R]=ramload; on ACCESS, dwait[R]=0, counter increments.
REQ-017 XFER/MEMRD return to IDLE in the cycle after the BLOCK_WORDS-th ACCESS; INV returns to IDLE after one cycle (upgrade, no data).
REQ-018 On leaving SNOOP/XFER/MEMRD/INV to IDLE, rr_ptr = (R+1) mod CPUS; counter clears.
REQ-019 ccwait stays asserted on all j!=R from SNOOP entry until return to IDLE.
REQ-020 IDLE with no cctrans: RAM port priority dWEN (round-robin) > iREN (separate round-robin); only granted CPU sees wait low on ACCESS.
REQ-021 Writeback dWEN arriving during a coherence transaction from a non-owner CPU stalls (dwait=1) until IDLE.
REQ-022 iREN of any CPU stalls whenever FSM is not IDLE or a dWEN is being served.
REQ-023 ramstate ERROR treated as BUSY (waits held high, no counter advance).
REQ-024 Only one of ramREN/ramWEN high in any cycle; ramaddr/ramstore zero when both low.
REQ-025 Outputs not driven by an active rule: waits=1, ccwait=ccinv=0, ccsnoopaddr=0, iload[j]=dload[j]=ramload.
REQ-026 Simultaneous cctrans from requester R and snooper-ack cannot alias: acks are only sampled in SNOOP; cctrans in IDLE is always a request.
REQ-027 Requester dropping cctrans mid-transaction is ignored; transaction completes on latched values.

Reset
REQ-028 RST high asynchronously forces IDLE, rr_ptr=0 for both arbiters, counter=0, all latches 0.
REQ-029 During reset, iwait=dwait=all ones, ccwait=ccinv=0, ramREN=ramWEN=0.
REQ-030 RST asserted mid-XFER/MEMRD aborts the transaction; no partial completion after release.

Verification
REQ-031 CPUS=2: cctrans[0], dREN[0], daddr=0x100, cache1 acks clean -> SNOOP, MEMRD, two ACCESS cycles, dwait[0] low twice, dload[0]=ramload, IDLE.
REQ-032 CPUS=4: cache2 holds dirty 0x200, cache0 reads -> ccwait[1..3]=1, XFER, dload[0]=dstore[2], ramWEN with ramaddr=0x200, dwait[0]=dwait[2]=0 on ACCESS.
REQ-033 CPUS=4: cctrans[1] and cctrans[3] same cycle, rr_ptr=2 -> CPU3 granted first, CPU1 next, rr_ptr=0 after.
REQ-034 cctrans[1]+ccwrite[1], dREN[1]=0 -> SNOOP with ccinv[0]=1, INV one cycle, IDLE, no RAM access.
REQ-035 iREN[0], dWEN[1] simultaneous in IDLE -> dWEN served first, iwait[0] held high until dwait[1] pulses low.
REQ-036 RST pulse during second XFER word -> IDLE next edge, all waits high, ramWEN=0.
